// File: rtl/pc_exception_unit.sv
// Exception-entry sequencer for the multicycle CPU: saves EPC, fetches the handler byte
// from the vector table and forces a PC load. Optional cause/lost reporting under EXC_CAUSE_EN.
module pc_exception_unit #(
   parameter int          MEM_LAT      = 2,
   parameter logic [31:0] VEC_OPCODE   = 32'd253,
   parameter logic [31:0] VEC_OVERFLOW = 32'd254,
   parameter logic [31:0] VEC_DIV0     = 32'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode,
   input  logic        exc_overflow,
   input  logic        exc_div0,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_data_in,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   output logic [31:0] handler_addr,
   output logic [31:0] epc_out,
   output logic [2:0]  pc_src_sel,
   output logic        pc_src_ovr,
   output logic        pc_write,
   output logic        busy,
   output logic        exc_ack
`ifdef EXC_CAUSE_EN
   ,
   output logic [1:0]  exc_cause,
   output logic        exc_lost
`endif
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SAVE  = 3'd1;
   localparam logic [2:0] FETCH = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] LOAD  = 3'd4;
   localparam logic [2:0] JUMP  = 3'd5;

   localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

   logic [2:0] state;
   logic [2:0] wait_cnt;
   logic [1:0] cause;
   logic       any_req;
   logic       unused_data_hi;

   assign any_req        = exc_opcode | exc_overflow | exc_div0;
   assign unused_data_hi = ^mem_data_in[31:8];

   // Cause code: 01 opcode, 10 overflow, 11 div0.
   function automatic logic [31:0] vector_of(input logic [1:0] c);
      case (c)
         2'b01:   vector_of = VEC_OPCODE;
         2'b10:   vector_of = VEC_OVERFLOW;
         default: vector_of = VEC_DIV0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wait_cnt     <= 3'd0;
         cause        <= 2'b00;
         epc_out      <= 32'd0;
         mem_addr     <= 32'd0;
         handler_addr <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= SAVE;
                  cause <= exc_opcode ? 2'b01 : (exc_overflow ? 2'b10 : 2'b11);
               end
            end
            SAVE: begin
               epc_out  <= pc_in - 32'd4;
               mem_addr <= vector_of(cause);
               state    <= FETCH;
            end
            FETCH: begin
               wait_cnt <= LAT_M1;
               state    <= (MEM_LAT == 1) ? LOAD : WAIT;
            end
            // Leave when the decremented count hits zero.
            WAIT: begin
               wait_cnt <= wait_cnt - 3'd1;
               if (wait_cnt == 3'd1) state <= LOAD;
            end
            LOAD: begin
               handler_addr <= {24'b0, mem_data_in[7:0]};
               state        <= JUMP;
            end
            JUMP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef EXC_CAUSE_EN
   assign exc_cause = cause;

   always_ff @(posedge clk) begin
      if (reset)
         exc_lost <= 1'b0;
      else if (state != IDLE && any_req)
         exc_lost <= 1'b1;
   end
`endif

   assign busy       = (state != IDLE);
   assign mem_req    = (state == FETCH);
   assign pc_src_ovr = busy;
   assign pc_src_sel = 3'b000;
   assign pc_write   = (state == JUMP);
   assign exc_ack    = (state == JUMP);

endmodule

// File: tb/tb_pc_exception_unit.sv
// Scoreboard bench for pc_exception_unit: expected entries are queued when a request is
// driven and compared when the DUT pulses pc_write; a latency-accurate memory model feeds data.
module tb_pc_exception_unit;

   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        exc_opcode = 1'b0;
   logic        exc_overflow = 1'b0;
   logic        exc_div0 = 1'b0;
   logic [31:0] pc_in = 32'd0;
   logic [31:0] mem_data_in = 32'd0;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic [31:0] handler_addr;
   logic [31:0] epc_out;
   logic [2:0]  pc_src_sel;
   logic        pc_src_ovr;
   logic        pc_write;
   logic        busy;
   logic        exc_ack;
`ifdef EXC_CAUSE_EN
   logic [1:0]  exc_cause;
   logic        exc_lost;
`endif

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mreq_n = 0;
   int          req_cd = 0;
   logic [31:0] mem_word = 32'd0;
   logic        lost_exp = 1'b0;

   typedef struct {
      logic [31:0] epc;
      logic [31:0] addr;
      logic [31:0] hnd;
      int          cyc;
      logic [1:0]  cause;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   pc_exception_unit #(.MEM_LAT(MEM_LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .exc_opcode   (exc_opcode),
      .exc_overflow (exc_overflow),
      .exc_div0     (exc_div0),
      .pc_in        (pc_in),
      .mem_data_in  (mem_data_in),
      .mem_addr     (mem_addr),
      .mem_req      (mem_req),
      .handler_addr (handler_addr),
      .epc_out      (epc_out),
      .pc_src_sel   (pc_src_sel),
      .pc_src_ovr   (pc_src_ovr),
      .pc_write     (pc_write),
      .busy         (busy),
      .exc_ack      (exc_ack)
`ifdef EXC_CAUSE_EN
      ,
      .exc_cause    (exc_cause),
      .exc_lost     (exc_lost)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory returns the word exactly MEM_LAT cycles after the mem_req cycle; garbage otherwise.
   always @(posedge clk) begin
      #1;
      mem_data_in = (req_cd == 1) ? mem_word : 32'hC3C3_C35A;
      if (req_cd > 0) req_cd--;
      if (mem_req) req_cd = MEM_LAT;
   end

   always @(negedge clk) begin
      if (reset) begin
         mreq_n = 0;
      end else begin
         if (mem_req) mreq_n++;
         if (pc_write) begin
            if (sb.size() == 0) begin
               check("spurious_pc_write", 32'(pc_write), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("epc_out", epc_out, mon_e.epc);
               check("mem_addr", mem_addr, mon_e.addr);
               check("handler_addr", handler_addr, mon_e.hnd);
               check("latency", 32'(cyc), 32'(mon_e.cyc));
               check("pc_src_sel", 32'(pc_src_sel), 32'd0);
               check("pc_src_ovr", 32'(pc_src_ovr), 32'd1);
               check("exc_ack", 32'(exc_ack), 32'd1);
               check("mem_req_pulses", 32'(mreq_n), 32'd1);
`ifdef EXC_CAUSE_EN
               check("exc_cause", 32'(exc_cause), 32'(mon_e.cause));
               check("exc_lost", 32'(exc_lost), 32'(lost_exp));
`endif
            end
            mreq_n = 0;
         end
      end
   end

   task automatic request(input logic op, input logic ov, input logic dz,
                          input logic [31:0] pc, input logic [31:0] word,
                          input logic [1:0] c, input logic [31:0] e_epc,
                          input logic [31:0] e_vec, input logic [31:0] e_hnd);
      @(negedge clk);
      pc_in = pc;
      mem_word = word;
      exc_opcode = op;
      exc_overflow = ov;
      exc_div0 = dz;
      sb.push_back('{epc: e_epc, addr: e_vec, hnd: e_hnd, cyc: cyc + MEM_LAT + 3, cause: c});
      @(negedge clk);
      check("busy_after_accept", 32'(busy), 32'd1);
      exc_opcode = 1'b0;
      exc_overflow = 1'b0;
      exc_div0 = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      // Reset held two cycles with an overflow request pending.
      reset = 1'b1;
      exc_overflow = 1'b1;
      pc_in = 32'h0000_0040;
      mem_word = 32'h0000_00A7;
      repeat (2) @(negedge clk);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_handler", handler_addr, 32'd0);
      check("rst_epc", epc_out, 32'd0);
      check("rst_sel", 32'(pc_src_sel), 32'd0);
      check("rst_ovr", 32'(pc_src_ovr), 32'd0);
      check("rst_pc_write", 32'(pc_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(exc_ack), 32'd0);
`ifdef EXC_CAUSE_EN
      check("rst_cause", 32'(exc_cause), 32'd0);
      check("rst_lost", 32'(exc_lost), 32'd0);
`endif
      reset = 1'b0;
      sb.push_back('{epc: 32'h3C, addr: 32'd254, hnd: 32'hA7, cyc: cyc + MEM_LAT + 3, cause: 2'b10});
      @(negedge clk);
      check("busy_after_reset_release", 32'(busy), 32'd1);
      exc_overflow = 1'b0;
      wait_idle();

      // Priority: opcode beats div0.
      request(1'b1, 1'b0, 1'b1, 32'h100, 32'h0000_0033, 2'b01, 32'hFC, 32'd253, 32'h33);
      wait_idle();

      // PC wrap-around and upper data bits ignored.
      request(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FF12, 2'b11, 32'hFFFF_FFFC, 32'd255, 32'h12);
      wait_idle();

      // Overflow pulsed while in WAIT is ignored but marks a lost request.
      request(1'b0, 1'b0, 1'b1, 32'h2000, 32'h0000_0181, 2'b11, 32'h1FFC, 32'd255, 32'h81);
      repeat (2) @(negedge clk);
      exc_overflow = 1'b1;
      lost_exp = 1'b1;
      @(negedge clk);
      exc_overflow = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("busy_req_ignored", 32'(busy), 32'd0);

      // Level held through the sequence is re-sampled in IDLE right after JUMP.
      @(negedge clk);
      pc_in = 32'h3000;
      mem_word = 32'h0000_0044;
      exc_opcode = 1'b1;
      sb.push_back('{epc: 32'h2FFC, addr: 32'd253, hnd: 32'h44, cyc: cyc + MEM_LAT + 3, cause: 2'b01});
      sb.push_back('{epc: 32'h2FFC, addr: 32'd253, hnd: 32'h44, cyc: cyc + 2 * MEM_LAT + 7, cause: 2'b01});
      repeat (7) @(negedge clk);
      exc_opcode = 1'b0;
      wait_idle();

      // Reset while waiting on memory aborts the sequence.
      @(negedge clk);
      pc_in = 32'h500;
      mem_word = 32'h0000_0077;
      exc_overflow = 1'b1;
      @(negedge clk);
      exc_overflow = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_pc_write", 32'(pc_write), 32'd0);
      check("mid_ack", 32'(exc_ack), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_epc", epc_out, 32'd0);
      check("mid_mem_addr", mem_addr, 32'd0);
      check("mid_handler", handler_addr, 32'd0);
`ifdef EXC_CAUSE_EN
      check("mid_cause", 32'(exc_cause), 32'd0);
      check("mid_lost", 32'(exc_lost), 32'd0);
`endif
      reset = 1'b0;
      lost_exp = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_stays_idle", 32'(busy), 32'd0);

      // Normal entry after the abort.
      request(1'b0, 1'b1, 1'b0, 32'h600, 32'h0000_ABCD, 2'b10, 32'h5FC, 32'd254, 32'hCD);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
